// File: rtl/bridge_16_32_pkg.sv
// bridge_pkg: shared types and helpers for the 16-to-32 bridge responder.
//   state_e      : responder FSM states (idle / downstream request / response)
//   lane_sel     : maps a halfword index and 2-bit byte enables onto 4 word lanes
//   half_extract : selects one halfword of a 32-bit word
package bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic [3:0] lane_sel(input logic hw, input logic [1:0] bs);
    return hw ? {bs, 2'b00} : {2'b00, bs};
  endfunction

  function automatic logic [15:0] half_extract(input logic hw, input logic [31:0] word);
    return hw ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/bridge_16_32_if.sv
// bridge_16_32_if: generic bridge bus (request held while bytesel != 0, one-cycle compl).
//   Parameterised so one definition serves the 16-bit initiator side
//   (AddrW=31, DataW=16, BselW=2) and the 32-bit target side (AddrW=30, DataW=32, BselW=4).
//   master : drives cs/addr/wdata/wr_en/bytesel, receives rdata/compl
//   slave  : receives cs/addr/wdata/wr_en/bytesel, drives rdata/compl
interface bridge_16_32_if #(
  parameter int unsigned AddrW = 31,
  parameter int unsigned DataW = 16,
  parameter int unsigned BselW = 2
);
  logic             cs;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] wdata;
  logic [DataW-1:0] rdata;
  logic             wr_en;
  logic [BselW-1:0] bytesel;
  logic             compl;

  modport master (output cs, addr, wdata, wr_en, bytesel, input rdata, compl);
  modport slave  (input cs, addr, wdata, wr_en, bytesel, output rdata, compl);
endinterface

// File: rtl/bridge_16_32_rdbuf.sv
// bridge_16_32_rdbuf: one-word read buffer {valid, tag, data}.
//   clk, rst_n   : clock, async active-low reset (buffer invalid after reset)
//   lookup_tag   : word address to compare; hit = valid && tag match
//   data         : buffered word
//   fill         : load upd_tag/fill_data and mark valid
//   merge        : write-through of merge_data lanes merge_be when upd_tag matches
//   inval        : clear valid; wins over a coincident fill or merge
module bridge_16_32_rdbuf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] lookup_tag,
  output logic        hit,
  output logic [31:0] data,
  input  logic        fill,
  input  logic        merge,
  input  logic [29:0] upd_tag,
  input  logic [31:0] fill_data,
  input  logic [3:0]  merge_be,
  input  logic [31:0] merge_data,
  input  logic        inval
);
  logic        valid_q, valid_d;
  logic [29:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign data = data_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill) begin
      valid_d = 1'b1;
      tag_d   = upd_tag;
      data_d  = fill_data;
    end else if (merge && valid_q && (tag_q == upd_tag)) begin
      for (int i = 0; i < 4; i++) begin
        if (merge_be[i]) data_d[8*i +: 8] = merge_data[8*i +: 8];
      end
    end
    if (inval) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/bridge_16_32.sv
// bridge_16_32: responder for the 16-bit bridge bus; performs each halfword access as a
// byte-laned access on a 32-bit target bus.
//   clk, rst_n : clock, async active-low reset (all outputs 0, FSM idle, buffer invalid)
//   s_bus      : 16-bit initiator side (slave modport)
//   m_bus      : 32-bit target side (master modport); cs/bytesel are combinational
//   inval      : read-buffer invalidate pulse
// Build option: define BRIDGE_16_32_RDBUF_EN to add the one-word read buffer.
module bridge_16_32
  import bridge_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  bridge_16_32_if.slave   s_bus,
  bridge_16_32_if.master  m_bus,
  input logic             inval
);
  state_e      state_q, state_d;
  logic [30:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic [1:0]  bs_q;
  logic [15:0] rdata_q, rdata_d;

  logic        start;
  logic        buf_hit;
  logic [31:0] buf_data;
  logic [3:0]  lanes;

  // s_compl is only ever high in StResp, so idle + nonzero bytesel is a fresh request.
  assign start = (state_q == StIdle) && (s_bus.bytesel != 2'b00);

`ifdef BRIDGE_16_32_RDBUF_EN
  logic fill;
  logic merge;

  assign fill  = (state_q == StReq) && m_bus.compl && !wr_q;
  assign merge = (state_q == StReq) && m_bus.compl && wr_q;
  // Reads fetch the whole word so the paired halfword can hit afterwards.
  assign lanes = wr_q ? lane_sel(addr_q[0], bs_q) : 4'hf;

  bridge_16_32_rdbuf u_rdbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (s_bus.addr[30:1]),
    .hit        (buf_hit),
    .data       (buf_data),
    .fill       (fill),
    .merge      (merge),
    .upd_tag    (addr_q[30:1]),
    .fill_data  (m_bus.rdata),
    .merge_be   (lane_sel(addr_q[0], bs_q)),
    .merge_data ({wdata_q, wdata_q}),
    .inval      (inval)
  );
`else
  logic unused_inval;

  assign unused_inval = inval;
  assign buf_hit      = 1'b0;
  assign buf_data     = '0;
  assign lanes        = lane_sel(addr_q[0], bs_q);
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!s_bus.wr_en && buf_hit) begin
            state_d = StResp;
            rdata_d = half_extract(s_bus.addr[0], buf_data);
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (m_bus.compl) begin
          state_d = StResp;
          rdata_d = wr_q ? 16'h0 : half_extract(addr_q[0], m_bus.rdata);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bs_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (start) begin
        addr_q  <= s_bus.addr;
        wdata_q <= s_bus.wdata;
        wr_q    <= s_bus.wr_en;
        bs_q    <= s_bus.bytesel;
      end
    end
  end

  // Lanes drop in the m_compl cycle so the target sees exactly one completed request.
  assign m_bus.bytesel = ((state_q == StReq) && !m_bus.compl) ? lanes : 4'b0000;
  assign m_bus.cs      = |m_bus.bytesel;
  assign m_bus.addr    = addr_q[30:1];
  assign m_bus.wdata   = {wdata_q, wdata_q};
  assign m_bus.wr_en   = wr_q;

  assign s_bus.compl = (state_q == StResp);
  assign s_bus.rdata = rdata_q;
endmodule

// File: tb/tb_bridge_16_32.sv
`timescale 1ns/1ps
module tb_bridge_16_32;
`ifdef BRIDGE_16_32_RDBUF_EN
  localparam bit RdBuf = 1'b1;
`else
  localparam bit RdBuf = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic inval;

  bridge_16_32_if #(.AddrW(31), .DataW(16), .BselW(2)) s_bus ();
  bridge_16_32_if #(.AddrW(30), .DataW(32), .BselW(4)) m_bus ();

  bridge_16_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (s_bus),
    .m_bus (m_bus),
    .inval (inval)
  );

  always #5 clk = ~clk;

  // Reference model: target memory plus which word (if any) the buffer holds.
  logic [31:0] mem [logic [29:0]];
  bit          buf_valid;
  logic [29:0] buf_tag;
  int          total;
  int          bad;

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  // One complete initiator transaction, also acting as the target with latency lat.
  task automatic access(input logic [30:0] addr, input logic wr, input logic [1:0] bs,
                        input logic [15:0] wd, input int lat, input bit inv, input string nm);
    logic [29:0] w;
    bit          hit;
    logic [3:0]  exp_bs;
    logic [31:0] word;
    logic [31:0] merged;
    logic [15:0] exp_rd;
    w      = addr[30:1];
    hit    = RdBuf && !wr && buf_valid && (buf_tag == w);
    exp_bs = (RdBuf && !wr) ? 4'hf : 4'({2'b00, bs} << (addr[0] ? 2 : 0));
    word   = mem_rd(w);
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (exp_bs[i]) merged[8*i +: 8] = wd[8*(i%2) +: 8];
    end
    exp_rd = wr ? 16'h0 : (addr[0] ? word[31:16] : word[15:0]);

    @(negedge clk);
    s_bus.addr    = addr;
    s_bus.wr_en   = wr;
    s_bus.bytesel = bs;
    s_bus.wdata   = wd;
    s_bus.cs      = 1'b1;

    if (hit) begin
      @(negedge clk);
      total++;
      if ({s_bus.compl, m_bus.cs, s_bus.rdata} !== {1'b1, 1'b0, exp_rd}) begin
        bad++;
        $display("FAIL %s hit: compl/cs/rdata got %b/%b/%h want 1/0/%h", nm,
                 s_bus.compl, m_bus.cs, s_bus.rdata, exp_rd);
      end
      s_bus.bytesel = 2'b00;
      s_bus.cs      = 1'b0;
    end else begin
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk);
        total++;
        if ({s_bus.compl, m_bus.cs, m_bus.bytesel, m_bus.addr, m_bus.wr_en} !==
            {1'b0, 1'b1, exp_bs, w, wr}) begin
          bad++;
          $display("FAIL %s req cyc%0d: compl=%b cs=%b be=%b addr=%h we=%b want 0 1 %b %h %b",
                   nm, i, s_bus.compl, m_bus.cs, m_bus.bytesel, m_bus.addr, m_bus.wr_en,
                   exp_bs, w, wr);
        end
        if (wr) begin
          total++;
          if (m_bus.wdata !== {wd, wd}) begin
            bad++;
            $display("FAIL %s wdata: got %h want %h", nm, m_bus.wdata, {wd, wd});
          end
        end
        // Held inputs may wander after the latch; the bridge must use its copy.
        s_bus.addr  = 31'($urandom);
        s_bus.wdata = 16'($urandom);
        s_bus.wr_en = 1'($urandom);
      end
      m_bus.compl = 1'b1;
      m_bus.rdata = wr ? 32'($urandom) : word;
      inval       = inv;
      #1;
      total++;
      if ({m_bus.cs, m_bus.bytesel} !== 5'b0) begin
        bad++;
        $display("FAIL %s drop: cs=%b be=%b want 0 0000", nm, m_bus.cs, m_bus.bytesel);
      end
      if (wr) mem[w] = merged;
      @(negedge clk);
      m_bus.compl = 1'b0;
      inval       = 1'b0;
      total++;
      if ({s_bus.compl, s_bus.rdata} !== {1'b1, exp_rd}) begin
        bad++;
        $display("FAIL %s resp: compl=%b rdata=%h want 1 %h", nm, s_bus.compl, s_bus.rdata,
                 exp_rd);
      end
      s_bus.bytesel = 2'b00;
      s_bus.cs      = 1'b0;
      if (!wr) begin
        buf_valid = RdBuf;
        buf_tag   = w;
      end
      if (inv) buf_valid = 1'b0;
    end

    @(negedge clk);
    total++;
    if ({s_bus.compl, m_bus.cs, s_bus.rdata} !== {1'b0, 1'b0, exp_rd}) begin
      bad++;
      $display("FAIL %s hold: compl=%b cs=%b rdata=%h want 0 0 %h", nm, s_bus.compl,
               m_bus.cs, s_bus.rdata, exp_rd);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    inval         = 1'b0;
    s_bus.cs      = 1'b0;
    s_bus.addr    = '0;
    s_bus.wdata   = '0;
    s_bus.wr_en   = 1'b0;
    s_bus.bytesel = 2'b00;
    m_bus.rdata   = '0;
    m_bus.compl   = 1'b0;
    buf_valid     = 1'b0;
    buf_tag       = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({s_bus.compl, s_bus.rdata, m_bus.cs, m_bus.bytesel, m_bus.addr, m_bus.wdata,
         m_bus.wr_en} !== '0) begin
      bad++;
      $display("FAIL reset: compl=%b rdata=%h cs=%b be=%b addr=%h wdata=%h we=%b want all 0",
               s_bus.compl, s_bus.rdata, m_bus.cs, m_bus.bytesel, m_bus.addr, m_bus.wdata,
               m_bus.wr_en);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    access(31'h11, 1'b1, 2'b11, 16'hBEEF, 2, 1'b0, "write");
  endtask

  task automatic test_read();
    mem[30'h10] = 32'h1234_5678;
    access(31'h20, 1'b0, 2'b11, 16'h0, 3, 1'b0, "read");
    total++;
    if (s_bus.rdata !== 16'h5678) begin
      bad++;
      $display("FAIL read_lo: got %h want 5678", s_bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    access(31'h20, 1'b0, 2'b11, 16'h0, 1, 1'b0, "b2b_lo");
    access(31'h21, 1'b0, 2'b11, 16'h0, 2, 1'b0, "b2b_hi");
    total++;
    if (s_bus.rdata !== 16'h1234) begin
      bad++;
      $display("FAIL b2b_hi_val: got %h want 1234", s_bus.rdata);
    end
  endtask

  task automatic test_merge();
    access(31'h10, 1'b0, 2'b11, 16'h0, 2, 1'b0, "merge_fill");
    access(31'h11, 1'b1, 2'b01, 16'h00AA, 1, 1'b0, "merge_wr");
    access(31'h11, 1'b0, 2'b11, 16'h0, 2, 1'b0, "merge_rd");
    total++;
    if (s_bus.rdata[7:0] !== 8'hAA) begin
      bad++;
      $display("FAIL merge_byte: got %h want aa", s_bus.rdata[7:0]);
    end
  endtask

  task automatic test_inval();
    access(31'h40, 1'b0, 2'b11, 16'h0, 2, 1'b1, "inval_fill");
    access(31'h41, 1'b0, 2'b11, 16'h0, 1, 1'b0, "inval_refetch");
  endtask

  task automatic test_reset_mid();
    access(31'h60, 1'b0, 2'b11, 16'h0, 1, 1'b0, "rst_prefill");
    @(negedge clk);
    s_bus.addr    = 31'h70;
    s_bus.wr_en   = 1'b0;
    s_bus.bytesel = 2'b11;
    s_bus.cs      = 1'b1;
    @(negedge clk);
    total++;
    if (m_bus.cs !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_active: cs=%b want 1", m_bus.cs);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_bus.cs, m_bus.bytesel, s_bus.compl, s_bus.rdata} !== '0) begin
      bad++;
      $display("FAIL rst_mid: cs=%b be=%b compl=%b rdata=%h want all 0", m_bus.cs,
               m_bus.bytesel, s_bus.compl, s_bus.rdata);
    end
    s_bus.bytesel = 2'b00;
    s_bus.cs      = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    buf_valid = 1'b0;
    access(31'h61, 1'b0, 2'b11, 16'h0, 2, 1'b0, "rst_after");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [30:0] a;
      a = 31'h100 + 31'($urandom_range(0, 7));
      access(a, 1'($urandom), 2'($urandom_range(1, 3)), 16'($urandom), $urandom_range(1, 4),
             ($urandom_range(0, 4) == 0), "random");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_merge();
    test_inval();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bridge_16_32.md
Name: bridge_16_32

Overview:
Responder for the 16-bit bridge bus, the target end of the interface that 32-to-16 splitting initiators drive. It accepts one 16-bit halfword access at a time and performs it as a byte-laned access on a 32-bit target bus. An optional one-word read buffer lets the paired halfword read of a split 32-bit access complete without a second downstream access.

Parameters:
None (widths fixed by the bus definitions: 31-bit halfword address, 30-bit word address).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
s_addr  in  31  halfword address; bit 0 selects the upper half
s_wdata  in  16  write data
s_rdata  out  16  read data, valid in the s_compl cycle
s_wr_en  in  1  1 = write, 0 = read
s_bytesel  in  2  byte enables; nonzero starts or holds a request
s_compl  out  1  one-cycle completion pulse
inval  in  1  read-buffer invalidate pulse (ignored without the feature)
m_cs  out  1  target chip select, high while m_bytesel is nonzero
m_addr  out  30  word address
m_wdata  out  32  write data
m_rdata  in  32  target read data, valid with m_compl
m_wr_en  out  1  target write enable
m_bytesel  out  4  target byte enables
m_compl  in  1  target one-cycle completion pulse

Behaviour:
- Reset, asynchronous, all outputs 0:
  - s_compl=0, s_rdata=0, m_cs=0, m_bytesel=0, m_addr=0, m_wdata=0, m_wr_en=0.
  - State returns to IDLE; the read buffer is invalidated.
  - Reset mid-access abandons the downstream transfer; m_bytesel drops immediately.
- Bus protocol, both sides:
  - The initiator holds addr/wdata/wr_en/bytesel stable while bytesel is nonzero.
  - The responder pulses compl for exactly one cycle.
  - The initiator may drop bytesel combinationally in the compl cycle and may start a new request the next cycle.
- States:
  - IDLE: when s_bytesel!=0 and s_compl=0, latch the request.
    - Buffer hit -> RESP.
    - Otherwise -> REQ.
  - REQ: downstream access active; on m_compl -> RESP.
  - RESP: one cycle with s_compl=1 -> IDLE.
  - Changes on s_* inputs after the latch are ignored.
- Downstream mapping:
  - m_addr = latched s_addr[30:1].
  - Lane enables: s_addr[0]=0 -> m_bytesel={2'b00,bs}; s_addr[0]=1 -> {bs,2'b00}.
  - Writes: m_wdata={s_wdata,s_wdata}; m_wr_en=1.
  - m_bytesel and m_cs are combinational: nonzero only in REQ, and forced to 0 in any cycle with m_compl=1.
- Read data: s_rdata is registered on entering RESP.
  - Value is the selected half of m_rdata, or of the buffer on a hit.
  - On write completion s_rdata=0.
  - Holds its value until the next response.
- Latency:
  - Miss/write: request seen in IDLE at cycle N; m_bytesel nonzero N+1..M, where m_compl is high at M; s_compl at M+1.
  - Hit: s_compl at N+1.
- Unsupported: m_compl outside REQ is ignored; no error signalling.

Optional Feature:
BRIDGE_16_32_RDBUF_EN
- Enabled:
  - Buffer holds {valid, tag[29:0], data[31:0]}.
  - Reads always request m_bytesel=4'b1111 and fill the buffer on m_compl.
  - A read with valid && tag==s_addr[30:1] hits and makes no downstream access.
  - Write completion to the tagged word merges the written lanes into the buffer (write-through).
  - inval clears valid at the next edge; inval coincident with a fill or merge wins, leaving the buffer invalid.
- Disabled:
  - No buffer; reads request only the addressed lanes; inval is unused.
  - Every access goes downstream.

Decomposition:
- Package bridge_pkg: state encoding constants (IDLE/REQ/RESP), lane-select function (halfword index, 2-bit bytesel -> 4-bit bytesel), halfword-extract function.
- One sub-module, bridge_16_32_rdbuf: tag/valid/data storage, hit compare, fill, lane merge, invalidate; instantiated only under BRIDGE_16_32_RDBUF_EN.

Test Plan:
- Write s_addr=31'h11, bytesel=2'b11, wdata=16'hBEEF -> m_addr=30'h8, m_bytesel=4'b1100, m_wdata=32'hBEEF_BEEF, m_wr_en=1; s_compl one cycle after m_compl; s_rdata=0.
- Read s_addr=31'h20, target returns 32'h1234_5678 with 3-cycle latency -> s_rdata=16'h5678 with s_compl; m_bytesel drops in the m_compl cycle.
- Back-to-back reads 31'h20 then 31'h21 (feature on) -> second completes 1 cycle after request with s_rdata=16'h1234, no m_cs; feature off -> second downstream access with m_bytesel=4'b1100.
- Read fills word 8, write 31'h11 bytesel=2'b01 wdata=16'h00AA, read 31'h11 -> hit returns merged upper half ending in 8'hAA.
- inval asserted in the same cycle as a fill's m_compl -> next read of the same word goes downstream.
- rst_n low while in REQ -> m_bytesel/m_cs=0 immediately; after release a new read completes normally and the buffer misses.
